coh_mem_responder: RTL and testbench
====================================

Name: coh_mem_responder

Overview:
- Memory-side responder of the snooping coherence bus; the other end of the cache controllers' request/response traffic.
- Consumes GETS/GETM/PUTM request messages.
- Keeps a per-line memory state (MI/MS/MEORM/MID/MSD) plus owner ID.
- Supplies data responses with EXCLUSIVE/DATA tags and absorbs owner writebacks carrying memory_flag=1.
- Backing store is an internal NUM_SETS-line register array with programmable access latency.

Parameters:
- NUM_SETS, 4, lines tracked and stored; line index = addr[5 +: INDEX_WIDTH] (32-byte lines); higher address bits alias.
- CACHELINE_SIZE, 256, line width in bits.
- MEM_LATENCY, 4, cycles from request accept to resp_valid for data responses; range 1..15.
- MEM_ID, 8 (NUM_CACHE), value driven on resp_source.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- req_valid  in  1  request message valid.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_source  in  4  requesting cache ID.
- req_addr  in  32  request address.
- req_bus_tx  in  2  bus_tx_t: GETS/GETM/PUTM/NONE.
- wb_valid  in  1  owner data message to memory (memory_flag=1); always accepted.
- wb_addr  in  32  writeback address.
- wb_data  in  256  writeback line.
- resp_valid  out  1  response valid.
- resp_ready  in  1  response consumed when resp_valid && resp_ready.
- resp_source  out  4  MEM_ID.
- resp_destination  out  4  requester ID.
- resp_memory_flag  out  1  always 0.
- resp_way  out  2  always 0.
- resp_addr  out  32  req_addr with bits [4:0] cleared.
- resp_data  out  256  line contents.
- resp_mmsg  out  2  memory_msg_t: EXCLUSIVE or DATA.

Behaviour:
- Reset: all entries MI, owner=0, line data=0, FSM READY, resp_* all 0.
- FSM states:
  - READY: accepts requests.
  - LAT: counter loaded with MEM_LATENCY-1, decrements to 0.
  - RESP: resp_valid held with fields stable until resp_ready.
  - RESP + resp_ready -> READY next cycle.
- Single outstanding data response.
- req_ready = (FSM==READY) && entry[idx] not in MID/MSD; combinational from registered state only.
- NONE: accepted, no effect.
- Per-line action on accept (idx from req_addr):
  - MI, GETS: data response EXCLUSIVE; -> MEORM; owner=src.
  - MI, GETM: DATA; -> MEORM; owner=src.
  - MS, GETS: DATA; stay MS.
  - MS, GETM: DATA; -> MEORM; owner=src.
  - MEORM, GETS from src!=owner: no response; -> MSD.
  - MEORM, GETM from src!=owner: no response; owner=src; stay MEORM.
  - MEORM, PUTM from owner: -> MID.
  - PUTM from non-owner, or in MI/MS: ignored (stale).
  - GETS/GETM from current owner in MEORM: ignored.
- Data-response transitions go READY -> LAT. When the counter reaches 0, go to RESP; resp_valid asserts exactly MEM_LATENCY cycles after the accept edge.
- Data is sampled from the array at the LAT->RESP transition.
- Non-data requests stay in READY, so back-to-back accepts are allowed.
- Writeback: if wb_valid and entry[wb idx] is MSD -> write line, -> MS; if MID -> write line, -> MI, owner=0. Otherwise dropped, no state change.
- A writeback and a request to the same idx in the same cycle: the request sees req_ready=0 (entry still in delay); it is accepted the following cycle against the updated state.
- A writeback to an idx with a pending LAT response updates the array; the response carries the updated data.
- MEORMD is never entered; encoding reserved.
- rst mid-LAT/RESP: response dropped, all state to reset values immediately.

Test Plan:
- Reset, GETS src=2 addr=0x40 (idx2) -> resp_valid exactly 4 cycles later: dest=2, mmsg=EXCLUSIVE, data=0, addr=0x40; entry MEORM owner=2.
- MI line, GETM src=1, then GETS src=3 same addr -> no memory response for src=3; req_ready=0 for idx until wb 0xA5..A5 arrives; then MS. A subsequent GETS src=5 returns DATA 0xA5..A5.
- MEORM owner=1, PUTM src=4 -> ignored, state unchanged. PUTM src=1 -> MID; wb data=0x1234 -> MI. Next GETS returns 0x1234 with EXCLUSIVE.
- resp_ready held 0 for 10 cycles -> resp fields stable; req_ready=0 throughout; the accept occurs the cycle after resp_ready=1.
- Writeback in the same cycle as a request to that idx in MSD -> request stalls one cycle, then served from MS with the new data. Writeback to an MI line -> dropped.
- Assert rst during LAT -> resp_valid stays 0, all lines MI, req_ready=1 after release.

Source files
------------

// File: rtl/coh_mem_responder.sv
// Memory-side responder for the snooping coherence bus: tracks per-line memory state and owner,
// returns line data after a fixed access latency and absorbs owner writebacks.
//
// state | meaning
// READY | idle, request port open
// LAT   | data response pending, latency down-counter running
// RESP  | resp_valid held with stable fields until resp_ready
module coh_mem_responder #(
  parameter int NUM_SETS       = 4,
  parameter int CACHELINE_SIZE = 256,
  parameter int MEM_LATENCY    = 4,
  parameter int MEM_ID         = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [3:0]                req_source,
  input  logic [31:0]               req_addr,
  input  logic [1:0]                req_bus_tx,
  input  logic                      wb_valid,
  input  logic [31:0]               wb_addr,
  input  logic [CACHELINE_SIZE-1:0] wb_data,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [3:0]                resp_source,
  output logic [3:0]                resp_destination,
  output logic                      resp_memory_flag,
  output logic [1:0]                resp_way,
  output logic [31:0]               resp_addr,
  output logic [CACHELINE_SIZE-1:0] resp_data,
  output logic [1:0]                resp_mmsg
);

  localparam int INDEX_WIDTH = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1;
  localparam logic [1:0] MSG_EXCLUSIVE = 2'd0;
  localparam logic [1:0] MSG_DATA      = 2'd1;

  typedef enum logic [1:0] {BUS_GETS = 2'd0, BUS_GETM = 2'd1, BUS_PUTM = 2'd2, BUS_NONE = 2'd3} bus_tx_t;
  typedef enum logic [2:0] {
    MEM_MI = 3'd0, MEM_MS = 3'd1, MEM_MEORM = 3'd2, MEM_MEORMD = 3'd3, MEM_MID = 3'd4, MEM_MSD = 3'd5
  } mem_state_t;
  typedef enum logic [1:0] {ST_READY = 2'd0, ST_LAT = 2'd1, ST_RESP = 2'd2} fsm_t;

  fsm_t                      state_q, state_d;
  logic [3:0]                cnt_q;
  logic [INDEX_WIDTH-1:0]    pend_idx;
  mem_state_t                line_state [NUM_SETS];
  logic [3:0]                line_owner [NUM_SETS];
  logic [CACHELINE_SIZE-1:0] line_data  [NUM_SETS];

  logic [INDEX_WIDTH-1:0] req_idx, wb_idx;
  bus_tx_t                req_tx;
  logic                   req_fire, owner_hit;
  logic                   act_resp, act_excl, act_upd;
  mem_state_t             act_state;
  logic [3:0]             act_owner;
  logic                   wb_to_ms, wb_to_mi;
  logic                   unused_bits;

  assign req_idx     = req_addr[5 +: INDEX_WIDTH];
  assign wb_idx      = wb_addr[5 +: INDEX_WIDTH];
  assign req_tx      = bus_tx_t'(req_bus_tx);
  assign unused_bits = ^{req_addr[4:0], wb_addr};

  assign req_ready = (state_q == ST_READY) &&
                     (line_state[req_idx] != MEM_MID) && (line_state[req_idx] != MEM_MSD);
  assign req_fire  = req_valid && req_ready;
  assign owner_hit = (req_source == line_owner[req_idx]);

  assign wb_to_ms = wb_valid && (line_state[wb_idx] == MEM_MSD);
  assign wb_to_mi = wb_valid && (line_state[wb_idx] == MEM_MID);

  assign resp_memory_flag = 1'b0;
  assign resp_way         = 2'b00;

  // Stale PUTMs and requests from the current owner fall through with no action.
  always_comb begin
    act_resp  = 1'b0;
    act_excl  = 1'b0;
    act_upd   = 1'b0;
    act_state = line_state[req_idx];
    act_owner = line_owner[req_idx];
    if (req_fire) begin
      case (req_tx)
        BUS_GETS: begin
          if (line_state[req_idx] == MEM_MI) begin
            act_resp  = 1'b1;
            act_excl  = 1'b1;
            act_upd   = 1'b1;
            act_state = MEM_MEORM;
            act_owner = req_source;
          end else if (line_state[req_idx] == MEM_MS) begin
            act_resp = 1'b1;
          end else if (line_state[req_idx] == MEM_MEORM && !owner_hit) begin
            act_upd   = 1'b1;
            act_state = MEM_MSD;
          end
        end
        BUS_GETM: begin
          if (line_state[req_idx] == MEM_MI || line_state[req_idx] == MEM_MS) begin
            act_resp  = 1'b1;
            act_upd   = 1'b1;
            act_state = MEM_MEORM;
            act_owner = req_source;
          end else if (line_state[req_idx] == MEM_MEORM && !owner_hit) begin
            act_upd   = 1'b1;
            act_owner = req_source;
          end
        end
        BUS_PUTM: begin
          if (line_state[req_idx] == MEM_MEORM && owner_hit) begin
            act_upd   = 1'b1;
            act_state = MEM_MID;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_READY: if (act_resp) state_d = ST_LAT;
      ST_LAT:   if (cnt_q == 4'd0) state_d = ST_RESP;
      ST_RESP:  if (resp_ready) state_d = ST_READY;
      default:  state_d = ST_READY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= ST_READY;
      cnt_q            <= 4'd0;
      pend_idx         <= '0;
      resp_valid       <= 1'b0;
      resp_source      <= 4'd0;
      resp_destination <= 4'd0;
      resp_addr        <= 32'd0;
      resp_data        <= '0;
      resp_mmsg        <= 2'd0;
      for (int i = 0; i < NUM_SETS; i++) begin
        line_state[i] <= MEM_MI;
        line_owner[i] <= 4'd0;
        line_data[i]  <= '0;
      end
    end else begin
      state_q <= state_d;
      if (state_q == ST_READY && act_resp) begin
        cnt_q            <= 4'(MEM_LATENCY - 1);
        pend_idx         <= req_idx;
        resp_destination <= req_source;
        resp_addr        <= {req_addr[31:5], 5'b0};
        resp_mmsg        <= act_excl ? MSG_EXCLUSIVE : MSG_DATA;
      end else if (state_q == ST_LAT && cnt_q != 4'd0) begin
        cnt_q <= cnt_q - 4'd1;
      end
      // Forward a same-edge writeback so the response never carries superseded data.
      if (state_q == ST_LAT && cnt_q == 4'd0) begin
        resp_valid  <= 1'b1;
        resp_source <= 4'(MEM_ID);
        resp_data   <= ((wb_to_ms || wb_to_mi) && wb_idx == pend_idx) ? wb_data : line_data[pend_idx];
      end
      if (state_q == ST_RESP && resp_ready) resp_valid <= 1'b0;
      if (act_upd) begin
        line_state[req_idx] <= act_state;
        line_owner[req_idx] <= act_owner;
      end
      if (wb_to_ms) begin
        line_state[wb_idx] <= MEM_MS;
        line_data[wb_idx]  <= wb_data;
      end else if (wb_to_mi) begin
        line_state[wb_idx] <= MEM_MI;
        line_owner[wb_idx] <= 4'd0;
        line_data[wb_idx]  <= wb_data;
      end
    end
  end

endmodule

// File: tb/tb_coh_mem_responder.sv
// Scoreboard bench for coh_mem_responder: directed scenarios then random traffic checked
// against a line-level ownership model.
module tb_coh_mem_responder;
  localparam int L = 4;
  localparam logic [1:0] GETS = 2'd0, GETM = 2'd1, PUTM = 2'd2, NONE = 2'd3;
  localparam logic [1:0] EXCL = 2'd0, DATA = 2'd1;
  // model line modes: memory owns, shared, cache owns, awaiting put data, awaiting share data
  localparam int FREE = 0, SHARED = 1, OWNED = 2, WAIT_PUT = 3, WAIT_SHR = 4;

  logic clk = 0, rst = 1;
  logic req_valid = 0, req_ready;
  logic [3:0] req_source = 0;
  logic [31:0] req_addr = 0;
  logic [1:0] req_bus_tx = NONE;
  logic wb_valid = 0;
  logic [31:0] wb_addr = 0;
  logic [255:0] wb_data = 0;
  logic resp_valid, resp_ready = 1;
  logic [3:0] resp_source, resp_destination;
  logic resp_memory_flag;
  logic [1:0] resp_way, resp_mmsg;
  logic [31:0] resp_addr;
  logic [255:0] resp_data;

  coh_mem_responder dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_source(req_source),
    .req_addr(req_addr), .req_bus_tx(req_bus_tx), .wb_valid(wb_valid), .wb_addr(wb_addr),
    .wb_data(wb_data), .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_source(resp_source),
    .resp_destination(resp_destination), .resp_memory_flag(resp_memory_flag), .resp_way(resp_way),
    .resp_addr(resp_addr), .resp_data(resp_data), .resp_mmsg(resp_mmsg));

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] dest; logic [31:0] addr; logic [255:0] data; logic [1:0] mmsg; int due;
  } exp_t;
  exp_t sb[$];

  int total = 0, bad = 0, cyc = 0, last_pop = -1;
  int m_mode [4];
  logic [3:0] m_owner [4];
  logic [255:0] m_data [4];
  logic rdy_cfg = 1;
  logic prev_v = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares the head of the scoreboard every cycle a response is presented.
  always @(negedge clk) begin
    if (rst) prev_v = 0;
    else begin
      if (resp_valid) begin
        if (sb.size() == 0) check("resp_without_request", resp_valid, 1'b0);
        else begin
          if (!prev_v) check("resp_latency", cyc, sb[0].due);
          check("resp_dest", resp_destination, sb[0].dest);
          check("resp_addr", resp_addr, sb[0].addr);
          check("resp_data", resp_data, sb[0].data);
          check("resp_mmsg", resp_mmsg, sb[0].mmsg);
          check("resp_source", resp_source, 4'd8);
          check("resp_flag_way", {resp_memory_flag, resp_way}, 3'b000);
          if (resp_ready) begin
            void'(sb.pop_front());
            last_pop = cyc;
          end
        end
      end
      prev_v = resp_valid;
    end
  end

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin
      m_mode[i] = FREE; m_owner[i] = 0; m_data[i] = '0;
    end
  endfunction

  function automatic void push(input logic [3:0] src, input logic [31:0] a, input logic [1:0] m);
    exp_t e;
    e.dest = src; e.addr = a & ~32'h1f; e.data = m_data[a[6:5]]; e.mmsg = m; e.due = cyc + 1 + L;
    sb.push_back(e);
  endfunction

  task automatic step(input logic rv, input logic [3:0] src, input logic [31:0] a, input logic [1:0] tx,
                      input logic wv, input logic [31:0] wa, input logic [255:0] wd);
    int i, wi;
    logic pend, exp_rdy;
    @(posedge clk); #1;
    req_valid = rv; req_source = src; req_addr = a; req_bus_tx = tx;
    wb_valid = wv; wb_addr = wa; wb_data = wd; resp_ready = rdy_cfg;
    @(negedge clk);
    i = int'(a[6:5]); wi = int'(wa[6:5]);
    pend = (sb.size() > 0) || (last_pop == cyc);
    exp_rdy = !pend && m_mode[i] != WAIT_PUT && m_mode[i] != WAIT_SHR;
    check("req_ready", req_ready, exp_rdy);
    if (wv && m_mode[wi] == WAIT_SHR) begin
      m_data[wi] = wd; m_mode[wi] = SHARED;
    end else if (wv && m_mode[wi] == WAIT_PUT) begin
      m_data[wi] = wd; m_mode[wi] = FREE; m_owner[wi] = 0;
    end
    if (rv && exp_rdy) begin
      case (tx)
        GETS: begin
          if (m_mode[i] == FREE) begin push(src, a, EXCL); m_mode[i] = OWNED; m_owner[i] = src; end
          else if (m_mode[i] == SHARED) push(src, a, DATA);
          else if (m_mode[i] == OWNED && src != m_owner[i]) m_mode[i] = WAIT_SHR;
        end
        GETM: begin
          if (m_mode[i] == FREE || m_mode[i] == SHARED) begin
            push(src, a, DATA); m_mode[i] = OWNED; m_owner[i] = src;
          end else if (m_mode[i] == OWNED && src != m_owner[i]) m_owner[i] = src;
        end
        PUTM: if (m_mode[i] == OWNED && src == m_owner[i]) m_mode[i] = WAIT_PUT;
        default: ;
      endcase
    end
  endtask

  task automatic req(input logic [3:0] src, input logic [31:0] a, input logic [1:0] tx);
    step(1, src, a, tx, 0, 0, '0);
  endtask

  task automatic wb(input logic [31:0] wa, input logic [255:0] wd);
    step(0, 0, 0, NONE, 1, wa, wd);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, NONE, 0, 0, '0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1; req_valid = 0; wb_valid = 0; resp_ready = 1; rdy_cfg = 1;
    sb.delete(); last_pop = -1; model_reset();
    repeat (2) begin
      @(negedge clk);
      check("resp_valid_in_reset", resp_valid, 1'b0);
    end
    @(posedge clk); #1 rst = 0;
  endtask

  initial begin
    logic [255:0] rd;
    model_reset();
    do_reset();
    @(negedge clk);
    check("reset_req_ready", req_ready, 1'b1);
    check("reset_resp", {resp_valid, resp_destination, resp_mmsg, resp_addr}, '0);
    check("reset_resp_data", resp_data, '0);

    // first fetch: exclusive, zero data, latency L
    req(4'd2, 32'h40, GETS);
    idle(L + 2);

    // owner then sharer: sharer stalls until the owner's data arrives
    req(4'd1, 32'h80, GETM);
    idle(L + 2);
    req(4'd3, 32'h80, GETS);
    req(4'd5, 32'h80, GETS);
    req(4'd5, 32'h80, GETS);
    step(1, 4'd5, 32'h80, GETS, 1, 32'h80, {32{8'hA5}});
    req(4'd5, 32'h80, GETS);
    idle(L + 2);

    // stale PUTM ignored, owner PUTM then writeback returns line to memory
    req(4'd1, 32'h20, GETM);
    idle(L + 2);
    req(4'd4, 32'h20, PUTM);
    req(4'd1, 32'h20, PUTM);
    req(4'd6, 32'h20, GETS);
    wb(32'h20, 256'h1234);
    req(4'd6, 32'h20, GETS);
    idle(L + 2);

    // consumer backpressure: fields must hold while resp_ready is low
    rdy_cfg = 0;
    req(4'd7, 32'h80, GETS);
    idle(L + 10);
    rdy_cfg = 1;
    req(4'd2, 32'h20, GETS);
    req(4'd2, 32'h20, GETS);
    idle(L + 2);

    // writeback to a memory-owned line is dropped
    wb(32'h60, {8{32'hDEADBEEF}});
    req(4'd3, 32'h60, GETS);
    idle(L + 2);

    // reset in the middle of the latency window
    req(4'd4, 32'hE0, GETM);
    idle(2);
    do_reset();
    idle(L + 3);
    req(4'd1, 32'h80, GETS);
    idle(L + 2);

    for (int n = 0; n < 400; n++) begin
      logic [31:0] a, wa;
      for (int k = 0; k < 8; k++) rd[k*32 +: 32] = $urandom;
      a = $urandom;
      wa = {$urandom_range(0, 3), 5'(0)} << 0;
      wa = {25'($urandom), 2'($urandom_range(0, 3)), 5'($urandom)};
      rdy_cfg = ($urandom_range(0, 3) != 0);
      step($urandom_range(0, 9) < 7, 4'($urandom_range(0, 5)), a, 2'($urandom_range(0, 3)),
           $urandom_range(0, 9) < 3, wa, rd);
    end

    rdy_cfg = 1;
    for (int k = 0; k < 100 && sb.size() > 0; k++) idle(1);
    check("drain_outstanding", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end
endmodule
